mem_agent_rd_engine: RTL and testbench

//  Parametrised AXI4 read-master engine for the memory agent. Sweeps the window
//  [ADDR_BASE, ADDR_HIGH) with fixed-length INCR bursts and keeps up to

---
 rtl/mem_agent_rd_engine_if.sv | 31 +++
 rtl/mem_agent_rd_engine.sv | 170 +++++++++++++++++
 tb/tb_mem_agent_rd_engine.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_agent_rd_engine_if.sv
// AXI4 read-channel bundle (AR + R) between the read engine and the memory port.
//   master : driven by the read engine (issues AR, accepts R)
//   slave  : driven by the memory side (accepts AR, returns R)
// Signals: araddr/arlen/arsize/arburst/arvalid/arready on AR,
//          rdata/rresp/rlast/rvalid/rready on R.
interface mem_agent_rd_engine_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/mem_agent_rd_engine.sv
// AXI4 read-master engine for the memory agent.
// Sweeps [ADDR_BASE, ADDR_HIGH) with fixed-length INCR bursts, keeping up to
// OUTSTANDING_MAX bursts in flight, and forwards every returned beat to a
// downstream FIFO. Supports single-pass and looping sweeps plus debug counters.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start/stop/loop_en sweep control (start pulse, stop level, wrap enable)
//   busy, done        status (busy in ISSUE/DRAIN, done one-cycle pulse)
//   m                 AXI AR/R channel bundle (master modport)
//   fifo_wdata/fifo_wrreq/fifo_full  downstream FIFO write port
//   outstanding       bursts currently in flight
//   dbg_ar_cnt/dbg_beat_cnt/dbg_err_cnt  event counters since last start
module mem_agent_rd_engine #(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    OUTSTANDING_MAX = 16,
    parameter int                    BURST_LEN       = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH       = 32'h4000_1000,
    parameter int                    CNT_BITS        = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic                                   loop_en,
    output logic                                   busy,
    output logic                                   done,
    mem_agent_rd_engine_if.master                  m,
    output logic [DATA_WIDTH-1:0]                  fifo_wdata,
    output logic                                   fifo_wrreq,
    input  logic                                   fifo_full,
    output logic [$clog2(OUTSTANDING_MAX+1)-1:0]   outstanding,
    output logic [CNT_BITS-1:0]                    dbg_ar_cnt,
    output logic [CNT_BITS-1:0]                    dbg_beat_cnt,
    output logic [CNT_BITS-1:0]                    dbg_err_cnt
);
    localparam int OUT_W       = $clog2(OUTSTANDING_MAX + 1);
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
    logic                    arvalid_reg, arvalid_next;
    logic [OUT_W-1:0]        outstanding_reg, outstanding_next;
    logic [CNT_BITS-1:0]     ar_cnt_reg, beat_cnt_reg, err_cnt_reg;
    logic                    clr_cnt;

    logic                    ar_hs, r_hs, rlast_hs;
    logic [ADDR_WIDTH:0]     addr_sum;
    logic                    addr_wrap;
    logic [ADDR_WIDTH-1:0]   addr_adv;

    // R path is purely combinational: the FIFO's full flag is the only
    // back-pressure, so beats flow in every state, including IDLE.
    assign m.rready   = ~fifo_full;
    assign fifo_wrreq = m.rvalid & ~fifo_full;
    assign fifo_wdata = m.rdata;

    assign m.araddr  = araddr_reg;
    assign m.arvalid = arvalid_reg;
    assign m.arlen   = 8'(BURST_LEN - 1);
    assign m.arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m.arburst = 2'b01;

    assign busy         = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done         = (state_reg == DONE);
    assign outstanding  = outstanding_reg;
    assign dbg_ar_cnt   = ar_cnt_reg;
    assign dbg_beat_cnt = beat_cnt_reg;
    assign dbg_err_cnt  = err_cnt_reg;

    assign ar_hs    = arvalid_reg & m.arready;
    assign r_hs     = m.rvalid & ~fifo_full;
    assign rlast_hs = r_hs & m.rlast;

    // One extra bit so the compare against ADDR_HIGH cannot be fooled by a
    // window that ends at the top of the address space.
    assign addr_sum  = {1'b0, araddr_reg} + (ADDR_WIDTH+1)'(BURST_BYTES);
    assign addr_wrap = (addr_sum >= {1'b0, ADDR_HIGH});
    assign addr_adv  = addr_wrap ? ADDR_BASE : addr_sum[ADDR_WIDTH-1:0];

    // In-flight tracking; a stray rlast with nothing outstanding is ignored.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (ar_hs && !rlast_hs) begin
            outstanding_next = outstanding_reg + OUT_W'(1);
        end else if (!ar_hs && rlast_hs && (outstanding_reg != '0)) begin
            outstanding_next = outstanding_reg - OUT_W'(1);
        end
    end

    always_comb begin
        state_next  = state_reg;
        araddr_next = araddr_reg;
        clr_cnt     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = ISSUE;
                    araddr_next = ADDR_BASE;
                    clr_cnt     = 1'b1;
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    araddr_next = addr_adv;
                    if (addr_wrap && !loop_en) begin
                        state_next = DRAIN;
                    end
                end else if (stop && !arvalid_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pending request is never withdrawn. A fresh one is raised only if
        // the in-flight count after this cycle leaves room for it, which keeps
        // outstanding bounded even though arvalid is registered.
        if (arvalid_reg && !m.arready) begin
            arvalid_next = 1'b1;
        end else begin
            arvalid_next = (state_next == ISSUE) && !stop &&
                           (outstanding_next < OUT_W'(OUTSTANDING_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            araddr_reg      <= ADDR_BASE;
            arvalid_reg     <= 1'b0;
            outstanding_reg <= '0;
            ar_cnt_reg      <= '0;
            beat_cnt_reg    <= '0;
            err_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            araddr_reg      <= araddr_next;
            arvalid_reg     <= arvalid_next;
            outstanding_reg <= outstanding_next;
            if (clr_cnt) begin
                ar_cnt_reg   <= '0;
                beat_cnt_reg <= '0;
                err_cnt_reg  <= '0;
            end else begin
                ar_cnt_reg   <= ar_cnt_reg + CNT_BITS'(ar_hs);
                beat_cnt_reg <= beat_cnt_reg + CNT_BITS'(r_hs);
                err_cnt_reg  <= err_cnt_reg + CNT_BITS'(r_hs && (m.rresp != 2'b00));
            end
        end
    end
endmodule

// File: tb/tb_mem_agent_rd_engine.sv
module tb_mem_agent_rd_engine;
    localparam int          DW   = 64;
    localparam int          AW   = 32;
    localparam int          BL   = 16;
    localparam int          NB   = 32;
    localparam int          BB   = 128;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        fifo_full = 1'b0;
    logic        busy, done, fifo_wrreq;
    logic [63:0] fifo_wdata;
    logic [4:0]  outstanding;
    logic [31:0] dbg_ar_cnt, dbg_beat_cnt, dbg_err_cnt;

    mem_agent_rd_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_if ();

    mem_agent_rd_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .busy         (busy),
        .done         (done),
        .m            (m_if),
        .fifo_wdata   (fifo_wdata),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_full    (fifo_full),
        .outstanding  (outstanding),
        .dbg_ar_cnt   (dbg_ar_cnt),
        .dbg_beat_cnt (dbg_beat_cnt),
        .dbg_err_cnt  (dbg_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: issued-burst queue, beat position, counters.
    logic [31:0] ar_q[$];
    int beat = 0, out_m = 0, n_ar = 0, n_beat = 0, n_err = 0, ar_idx = 0;
    int done_cnt = 0, err_left = 0;
    bit model_idle = 1, chk_en = 0, prev_pend = 0;
    bit rv_en = 0, rv_rand = 0, ar_rand = 0, full_rand = 0, ar_on_last = 0, one_burst = 0;
    logic [31:0] prev_addr = '0, last_ar = '0, cap33 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] a, input int b);
        return {a + 32'(b * 8), 32'hA5A5_0000 ^ 32'(b)};
    endfunction

    // One clock: check at negedge, advance the model just after posedge, then
    // drive the memory side for the next cycle.
    task automatic tick();
        logic ar_hs, r_hs, r_last, held;
        logic [31:0] s_addr;
        logic [1:0]  s_resp;
        @(negedge clk);
        if (chk_en) begin
            chk("rready", 64'(m_if.rready), 64'(!fifo_full));
            chk("wrreq", 64'(fifo_wrreq), 64'(m_if.rvalid && !fifo_full));
            chk("wdata", fifo_wdata, m_if.rdata);
            chk("outstanding", 64'(outstanding), 64'(out_m));
            chk("ar_cnt", 64'(dbg_ar_cnt), 64'(n_ar));
            chk("beat_cnt", 64'(dbg_beat_cnt), 64'(n_beat));
            chk("err_cnt", 64'(dbg_err_cnt), 64'(n_err));
            if (prev_pend) begin
                chk("ar_hold", 64'(m_if.arvalid), 64'(1));
                chk("ar_stable", 64'(m_if.araddr), 64'(prev_addr));
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("out_at_done", 64'(outstanding), 64'(0));
                model_idle = 1;
            end
            if (fifo_wrreq === 1'b1) begin
                chk("push_expected", 64'(ar_q.size() != 0), 64'(1));
                if (ar_q.size() != 0) chk("push_data", fifo_wdata, data_of(ar_q[0], beat));
            end
        end
        ar_hs  = (m_if.arvalid === 1'b1) && m_if.arready;
        r_hs   = m_if.rvalid && !fifo_full;
        r_last = r_hs && m_if.rlast;
        s_addr = m_if.araddr;
        s_resp = m_if.rresp;
        if (ar_hs) begin
            chk("araddr", 64'(s_addr), 64'(BASE + 32'((ar_idx % NB) * BB)));
            if (ar_idx == 32) cap33 = s_addr;
            last_ar = s_addr;
        end
        prev_pend = (m_if.arvalid === 1'b1) && !m_if.arready;
        prev_addr = s_addr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ar_q.delete();
            beat = 0; out_m = 0; n_ar = 0; n_beat = 0; n_err = 0; ar_idx = 0;
            model_idle = 1; prev_pend = 0;
        end else begin
            if (start && model_idle) begin
                n_ar = 0; n_beat = 0; n_err = 0; ar_idx = 0; model_idle = 0;
            end else begin
                n_ar += int'(ar_hs);
                n_beat += int'(r_hs);
                n_err += int'(r_hs && s_resp != 2'b00);
            end
            if (ar_hs) begin
                ar_q.push_back(s_addr);
                ar_idx++;
                out_m++;
            end
            if (r_hs) begin
                if (s_resp != 2'b00 && err_left > 0) err_left--;
                beat++;
                if (r_last) begin
                    if (ar_q.size() > 0) void'(ar_q.pop_front());
                    beat = 0;
                    if (out_m > 0) out_m--;
                    if (one_burst) begin rv_en = 0; one_burst = 0; end
                end
            end
        end
        held  = m_if.rvalid && !r_hs;
        start = 1'b0;
        if (full_rand) fifo_full = ($urandom_range(0, 3) == 0);
        if (ar_rand) m_if.arready = 1'($urandom_range(0, 1));
        if (ar_q.size() > 0 && (held || (rv_en && (!rv_rand || $urandom_range(0, 2) != 0)))) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = data_of(ar_q[0], beat);
            m_if.rlast  = (beat == BL - 1);
            m_if.rresp  = (err_left > 0) ? 2'b10 : 2'b00;
        end else begin
            m_if.rvalid = 1'b0;
            m_if.rlast  = 1'b0;
            m_if.rresp  = 2'b00;
        end
        if (ar_on_last) m_if.arready = m_if.rvalid && m_if.rlast;
    endtask

    task automatic run_until_done(input int maxc);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < maxc) begin tick(); i++; end
        chk("done_seen", 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_araddr"}, 64'(m_if.araddr), 64'(BASE));
        chk({tag, "_arvalid"}, 64'(m_if.arvalid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_out"}, 64'(outstanding), 64'(0));
        chk({tag, "_arcnt"}, 64'(dbg_ar_cnt), 64'(0));
        chk({tag, "_beatcnt"}, 64'(dbg_beat_cnt), 64'(0));
        chk({tag, "_errcnt"}, 64'(dbg_err_cnt), 64'(0));
    endtask

    initial begin
        int i, nb0, n0;
        logic [31:0] a;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0;
        m_if.rresp = 2'b00; m_if.rlast = 1'b0;

        rst_n = 1'b0; tick(); tick();
        chk_reset_state("reset");
        chk("arlen", 64'(m_if.arlen), 64'(15));
        chk("arsize", 64'(m_if.arsize), 64'(3));
        chk("arburst", 64'(m_if.arburst), 64'(1));
        rst_n = 1'b1; chk_en = 1; tick();

        // Single pass, arready=1, full bursts returned; a mid-sweep start is ignored.
        m_if.arready = 1'b1; rv_en = 1; start = 1'b1; tick();
        chk("t1_busy", 64'(busy), 64'(1));
        repeat (50) tick();
        start = 1'b1; tick();
        run_until_done(3000);
        chk("t1_ar", 64'(dbg_ar_cnt), 64'(32));
        chk("t1_beats", 64'(dbg_beat_cnt), 64'(512));
        chk("t1_last_ar", 64'(last_ar), 64'(32'h4000_0F80));
        tick();
        chk("t1_done_low", 64'(done), 64'(0));
        chk("t1_idle", 64'(busy), 64'(0));

        // No read data: exactly 16 bursts in flight, one returned burst frees one slot.
        rv_en = 0; start = 1'b1; tick();
        repeat (40) tick();
        chk("t2_ar16", 64'(dbg_ar_cnt), 64'(16));
        chk("t2_arvalid0", 64'(m_if.arvalid), 64'(0));
        chk("t2_out16", 64'(outstanding), 64'(16));
        one_burst = 1; rv_en = 1; repeat (30) tick();
        chk("t2_ar17", 64'(dbg_ar_cnt), 64'(17));
        chk("t2_out16b", 64'(outstanding), 64'(16));

        // Pending AR at 15 in flight, then rlast and AR handshake in the same cycle.
        m_if.arready = 1'b0; one_burst = 1; rv_en = 1; repeat (30) tick();
        chk("t3_out15", 64'(outstanding), 64'(15));
        chk("t3_pending", 64'(m_if.arvalid), 64'(1));
        chk("t3_ar17", 64'(dbg_ar_cnt), 64'(17));
        ar_on_last = 1; one_burst = 1; rv_en = 1; repeat (30) tick();
        chk("t3_out_stays", 64'(outstanding), 64'(15));
        chk("t3_ar18", 64'(dbg_ar_cnt), 64'(18));
        chk("t3_pending2", 64'(m_if.arvalid), 64'(1));
        ar_on_last = 0; m_if.arready = 1'b1; rv_en = 1;
        run_until_done(3000);
        chk("t3_ar_total", 64'(dbg_ar_cnt), 64'(32));
        chk("t3_beats", 64'(dbg_beat_cnt), 64'(512));

        // FIFO full for 10 cycles with a beat presented.
        start = 1'b1; tick();
        repeat (6) tick();
        chk("t4_rvalid", 64'(m_if.rvalid), 64'(1));
        fifo_full = 1'b1; nb0 = n_beat;
        repeat (10) begin
            tick();
            chk("t4_rready0", 64'(m_if.rready), 64'(0));
            chk("t4_wrreq0", 64'(fifo_wrreq), 64'(0));
        end
        chk("t4_frozen", 64'(dbg_beat_cnt), 64'(nb0));
        fifo_full = 1'b0; tick();
        chk("t4_resume", 64'(dbg_beat_cnt), 64'(nb0 + 1));
        run_until_done(3000);
        chk("t4_beats", 64'(dbg_beat_cnt), 64'(512));

        // Looping sweep, then stop while an AR is pending.
        loop_en = 1'b1; rv_rand = 1; start = 1'b1; tick();
        i = 0;
        while (n_ar < 33 && i < 3000) begin tick(); i++; end
        chk("t5_ar33_addr", 64'(cap33), 64'(BASE));
        m_if.arready = 1'b0;
        i = 0;
        while (m_if.arvalid !== 1'b1 && i < 200) begin tick(); i++; end
        chk("t5_pend", 64'(m_if.arvalid), 64'(1));
        a = BASE + 32'((ar_idx % NB) * BB);
        stop = 1'b1; repeat (5) tick();
        chk("t5_hold", 64'(m_if.arvalid), 64'(1));
        chk("t5_addr", 64'(m_if.araddr), 64'(a));
        chk("t5_busy", 64'(busy), 64'(1));
        m_if.arready = 1'b1; tick(); m_if.arready = 1'b0;
        n0 = n_ar;
        repeat (3) tick();
        chk("t5_arvalid_off", 64'(m_if.arvalid), 64'(0));
        run_until_done(3000);
        chk("t5_no_more_ar", 64'(dbg_ar_cnt), 64'(n0));
        stop = 1'b0; loop_en = 1'b0; rv_rand = 0; m_if.arready = 1'b1;

        // Error responses, then reset mid-burst and restart.
        err_left = 3; start = 1'b1; tick();
        repeat (60) tick();
        chk("t6_err3", 64'(dbg_err_cnt), 64'(3));
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk_reset_state("t6_rst");
        tick();
        start = 1'b1; tick();
        run_until_done(3000);
        chk("t6_beats", 64'(dbg_beat_cnt), 64'(512));
        chk("t6_err0", 64'(dbg_err_cnt), 64'(0));

        // Fully randomized handshakes and back-pressure.
        ar_rand = 1; rv_rand = 1; full_rand = 1; start = 1'b1; tick();
        run_until_done(8000);
        chk("rnd_ar", 64'(dbg_ar_cnt), 64'(32));
        chk("rnd_beats", 64'(dbg_beat_cnt), 64'(512));
        chk("rnd_out", 64'(outstanding), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
